// File: rtl/rv_iommu_atr_ingress_if.sv
// Handshake bundle between devices, the ingress queue, the walker and the completion path.
// The slave modport is the queue's view; the master modport is the view of whoever drives it.
interface rv_iommu_atr_ingress_if #(
  parameter int REQ_W = 113
);
  logic [REQ_W-1:0] dev_req_i;
  logic             dev_irdy_i;
  logic             dev_trdy_o;
  logic [REQ_W-1:0] atr_req_o;
  logic             atr_irdy_o;
  logic             atr_trdy_i;
  logic             atc_irdy_i;
  logic             atc_trdy_i;

  modport slave (
    input  dev_req_i, dev_irdy_i, atr_trdy_i, atc_irdy_i, atc_trdy_i,
    output dev_trdy_o, atr_req_o, atr_irdy_o
  );

  modport master (
    output dev_req_i, dev_irdy_i, atr_trdy_i, atc_irdy_i, atc_trdy_i,
    input  dev_trdy_o, atr_req_o, atr_irdy_o
  );
endinterface

// File: rtl/rv_iommu_atr_ingress.sv
// Ingress FIFO ahead of the IOMMU translation request bus, throttling issue to
// MAX_OUTSTANDING in-flight translations by observing completion handshakes.
module rv_iommu_atr_ingress #(
  parameter  int DEPTH           = 4,
  parameter  int MAX_OUTSTANDING = 8,
  parameter  int REQ_W           = 113,
  localparam int PTR_W           = $clog2(DEPTH),
  localparam int OCC_W           = $clog2(DEPTH + 1),
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  rv_iommu_atr_ingress_if.slave         bus,
  output logic [OCC_W-1:0]              occupancy_o,
  output logic [OUT_W-1:0]              outstanding_o,
  output logic                          cpl_underflow_o
);

  logic [REQ_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ_cnt;
  logic [OUT_W-1:0] out_cnt;
  logic             underflow;

  logic push;
  logic pop;
  logic cpl;

  // Ready/valid depend only on registered counts, so dev_* never reaches atr_* combinationally.
  assign bus.dev_trdy_o = (occ_cnt != OCC_W'(DEPTH));
  assign bus.atr_irdy_o = (occ_cnt != '0) && (out_cnt < OUT_W'(MAX_OUTSTANDING));
  // Empty head reads as zero so the unreset storage never leaks X after reset.
  assign bus.atr_req_o  = (occ_cnt != '0) ? mem[rd_ptr] : '0;

  assign push = bus.dev_irdy_i & bus.dev_trdy_o;
  assign pop  = bus.atr_irdy_o & bus.atr_trdy_i;
  assign cpl  = bus.atc_irdy_i & bus.atc_trdy_i;

  assign occupancy_o     = occ_cnt;
  assign outstanding_o   = out_cnt;
  assign cpl_underflow_o = underflow;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.dev_req_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        occ_cnt <= occ_cnt + OCC_W'(1);
      end else if (pop && !push) begin
        occ_cnt <= occ_cnt - OCC_W'(1);
      end
    end
  end

  // Pop is already gated by the outstanding limit, so the counter cannot exceed it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt   <= '0;
      underflow <= 1'b0;
    end else begin
      if (pop && !cpl) begin
        out_cnt <= out_cnt + OUT_W'(1);
      end else if (cpl && !pop) begin
        if (out_cnt == '0) begin
          underflow <= 1'b1;
        end else begin
          out_cnt <= out_cnt - OUT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_iommu_atr_ingress.sv
// Directed bench for rv_iommu_atr_ingress with DEPTH=4, MAX_OUTSTANDING=8.
module tb_rv_iommu_atr_ingress;
  localparam int REQ_W = 113;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] occupancy;
  logic [3:0] outstanding;
  logic       cpl_underflow;

  int n_vec = 0;
  int n_err = 0;

  rv_iommu_atr_ingress_if #(.REQ_W(REQ_W)) bus ();

  rv_iommu_atr_ingress #(
    .DEPTH(4),
    .MAX_OUTSTANDING(8),
    .REQ_W(REQ_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus.slave),
    .occupancy_o     (occupancy),
    .outstanding_o   (outstanding),
    .cpl_underflow_o (cpl_underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [REQ_W-1:0] mk_req(input logic [51:0] iova, input logic [7:0] tag);
    return {iova, 24'h0ABCDE, 20'h00001, 2'b01, 6'b100001, 1'b0, tag};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pushed;
    int cyc;
    logic [REQ_W-1:0] r1;

    rst_n          = 1'b0;
    bus.dev_req_i  = '0;
    bus.dev_irdy_i = 1'b0;
    bus.atr_trdy_i = 1'b0;
    bus.atc_irdy_i = 1'b0;
    bus.atc_trdy_i = 1'b0;
    step();
    step();
    chk("rst_dev_trdy", bus.dev_trdy_o, 1);
    chk("rst_atr_irdy", bus.atr_irdy_o, 0);
    chk("rst_atr_req", bus.atr_req_o, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_out", outstanding, 0);
    chk("rst_underflow", cpl_underflow, 0);
    rst_n = 1'b1;
    step();

    // Single request, 1-cycle latency, then taken by the walker.
    r1 = mk_req(52'h1234, 8'h5A);
    bus.dev_req_i  = r1;
    bus.dev_irdy_i = 1'b1;
    bus.atr_trdy_i = 1'b1;
    chk("t1_no_comb_path", bus.atr_irdy_o, 0);
    step();
    bus.dev_irdy_i = 1'b0;
    chk("t1_irdy", bus.atr_irdy_o, 1);
    chk("t1_req", bus.atr_req_o, r1);
    chk("t1_occ", occupancy, 1);
    step();
    chk("t1_out", outstanding, 1);
    chk("t1_occ_empty", occupancy, 0);
    chk("t1_irdy_low", bus.atr_irdy_o, 0);

    // Fill to full with the walker stalled.
    bus.atr_trdy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.dev_req_i  = mk_req(52'h100 + 52'(i), 8'h10 + 8'(i));
      bus.dev_irdy_i = 1'b1;
      step();
    end
    chk("t2_full_trdy", bus.dev_trdy_o, 0);
    chk("t2_full_occ", occupancy, 4);
    bus.dev_req_i = mk_req(52'h999, 8'h99);
    step();
    chk("t2_held_occ", occupancy, 4);
    chk("t2_head0", bus.atr_req_o[7:0], 8'h10);
    bus.atr_trdy_i = 1'b1;
    step();
    bus.dev_irdy_i = 1'b0;
    chk("t2_no_bypass_occ", occupancy, 3);
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("t2_order%0d", k), bus.atr_req_o[7:0], 8'h10 + 8'(k));
      step();
    end
    chk("t2_drained", occupancy, 0);
    chk("t2_out", outstanding, 5);

    bus.atr_trdy_i = 1'b0;
    bus.atc_irdy_i = 1'b1;
    bus.atc_trdy_i = 1'b1;
    for (int k = 0; k < 5; k++) step();
    bus.atc_irdy_i = 1'b0;
    chk("t3_pre_out", outstanding, 0);
    chk("t3_pre_uf", cpl_underflow, 0);

    // Nine requests, no completions: the ninth must wait for one completion.
    bus.atr_trdy_i = 1'b1;
    pushed = 0;
    cyc = 0;
    while (pushed < 9 && cyc < 40) begin
      bus.dev_req_i  = mk_req(52'h200 + 52'(pushed), 8'h20 + 8'(pushed));
      bus.dev_irdy_i = 1'b1;
      if (bus.dev_trdy_o) pushed++;
      step();
      cyc++;
    end
    bus.dev_irdy_i = 1'b0;
    chk("t3_pushed", pushed, 9);
    for (int k = 0; k < 10; k++) step();
    chk("t3_out_cap", outstanding, 8);
    chk("t3_irdy_blocked", bus.atr_irdy_o, 0);
    chk("t3_occ_left", occupancy, 1);
    bus.atc_irdy_i = 1'b1;
    step();
    bus.atc_irdy_i = 1'b0;
    chk("t3_out_after_cpl", outstanding, 7);
    chk("t3_irdy_again", bus.atr_irdy_o, 1);
    chk("t3_ninth_tag", bus.atr_req_o[7:0], 8'h28);
    step();
    chk("t3_ninth_popped_out", outstanding, 8);
    chk("t3_ninth_popped_occ", occupancy, 0);

    // Simultaneous pop+cpl at outstanding 3, then push+pop at occupancy 2.
    bus.atr_trdy_i = 1'b0;
    bus.atc_irdy_i = 1'b1;
    for (int k = 0; k < 5; k++) step();
    bus.atc_irdy_i = 1'b0;
    chk("t4_out3", outstanding, 3);
    bus.dev_req_i  = mk_req(52'h300, 8'h40);
    bus.dev_irdy_i = 1'b1;
    step();
    bus.dev_irdy_i = 1'b0;
    bus.atr_trdy_i = 1'b1;
    bus.atc_irdy_i = 1'b1;
    step();
    bus.atr_trdy_i = 1'b0;
    bus.atc_irdy_i = 1'b0;
    chk("t4_popcpl_out", outstanding, 3);
    chk("t4_popcpl_occ", occupancy, 0);
    bus.dev_irdy_i = 1'b1;
    bus.dev_req_i  = mk_req(52'h301, 8'h41);
    step();
    bus.dev_req_i  = mk_req(52'h302, 8'h42);
    step();
    chk("t4_occ2", occupancy, 2);
    bus.dev_req_i  = mk_req(52'h303, 8'h43);
    bus.atr_trdy_i = 1'b1;
    step();
    bus.dev_irdy_i = 1'b0;
    chk("t4_pushpop_occ", occupancy, 2);
    chk("t4_pushpop_out", outstanding, 4);
    chk("t4_head", bus.atr_req_o[7:0], 8'h42);
    step();
    step();
    bus.atr_trdy_i = 1'b0;
    chk("t4_drain_out", outstanding, 6);

    // Completion with nothing outstanding.
    bus.atc_irdy_i = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("t5_out0", outstanding, 0);
    chk("t5_uf_clear", cpl_underflow, 0);
    step();
    bus.atc_irdy_i = 1'b0;
    chk("t5_uf_set", cpl_underflow, 1);
    chk("t5_out_stays0", outstanding, 0);
    step();
    chk("t5_uf_sticky", cpl_underflow, 1);

    // Asynchronous reset with work in flight.
    bus.atr_trdy_i = 1'b1;
    bus.dev_irdy_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.dev_req_i = mk_req(52'h400 + 52'(k), 8'h50 + 8'(k));
      step();
    end
    bus.dev_irdy_i = 1'b0;
    step();
    bus.atr_trdy_i = 1'b0;
    bus.dev_irdy_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.dev_req_i = mk_req(52'h500 + 52'(k), 8'h60 + 8'(k));
      step();
    end
    bus.dev_irdy_i = 1'b0;
    chk("t6_pre_occ", occupancy, 3);
    chk("t6_pre_out", outstanding, 5);
    bus.atr_trdy_i = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_occ", occupancy, 0);
    chk("t6_async_out", outstanding, 0);
    chk("t6_async_uf", cpl_underflow, 0);
    chk("t6_async_irdy", bus.atr_irdy_o, 0);
    chk("t6_async_trdy", bus.dev_trdy_o, 1);
    chk("t6_async_req", bus.atr_req_o, 0);
    step();
    chk("t6_held_out", outstanding, 0);
    rst_n = 1'b1;
    bus.atr_trdy_i = 1'b0;
    bus.dev_req_i  = mk_req(52'h777, 8'h77);
    bus.dev_irdy_i = 1'b1;
    step();
    bus.dev_irdy_i = 1'b0;
    chk("t6_post_req", bus.atr_req_o, mk_req(52'h777, 8'h77));
    chk("t6_post_occ", occupancy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
